// File: rtl/ascon_job_sequencer_pkg.sv
// Shared types and widths for the Ascon job sequencer and its memory arbiter.
package ascon_job_sequencer_pkg;

  localparam int unsigned MEM_AW  = 8;
  localparam int unsigned DATA_AW = 7;
  localparam int unsigned WORD_W  = 64;
  localparam int unsigned TAG_W   = 128;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    DONE
  } job_state_e;

  typedef struct packed {
    logic              we;
    logic [MEM_AW-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/ascon_mem_arb.sv
// Two-requester fixed-priority memory arbiter (write over read); the accepted
// request is registered and held on the port until granted.
module ascon_mem_arb
  import ascon_job_sequencer_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     wr_req,
  input  mem_req_t wr,
  input  logic     rd_req,
  input  mem_req_t rd,
  output logic     rd_take_c,
  input  logic     gnt,
  output logic     req,
  output mem_req_t cmd
);

  // A read is only taken into the port register when no write competes.
  always_comb begin
    rd_take_c = !req && !wr_req && rd_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req <= 1'b0;
      cmd <= '0;
    end else if (req) begin
      if (gnt) begin
        req <= 1'b0;
        cmd <= '0;
      end
    end else if (wr_req) begin
      req <= 1'b1;
      cmd <= wr;
    end else if (rd_req) begin
      req <= 1'b1;
      cmd <= rd;
    end
  end

endmodule

// File: rtl/ascon_job_sequencer.sv
// Moves one AEAD job between scratch memory and ascon_wrapper: AD/PT words in,
// CT words out, tag captured, done pulsed.
module ascon_job_sequencer
  import ascon_job_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               job_start_i,
  input  logic [MEM_AW-1:0]  ad_base_i,
  input  logic [MEM_AW-1:0]  pt_base_i,
  input  logic [MEM_AW-1:0]  ct_base_i,
  input  logic [DATA_AW-1:0] ad_size_i,
  input  logic [DATA_AW-1:0] pt_size_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [MEM_AW-1:0]  mem_addr_o,
  output logic [WORD_W-1:0]  mem_wdata_o,
  input  logic               mem_gnt_i,
  input  logic [WORD_W-1:0]  mem_rdata_i,
  output logic               asc_start_o,
  input  logic               asc_ready_i,
  output logic [DATA_AW-1:0] asc_ad_size_o,
  output logic [DATA_AW-1:0] asc_pt_size_o,
  input  logic               asc_tag_valid_i,
  input  logic [TAG_W-1:0]   asc_tag_i,
  output logic               ad_push_o,
  output logic [WORD_W-1:0]  ad_o,
  input  logic               ad_full_i,
  output logic               pt_push_o,
  output logic [WORD_W-1:0]  pt_o,
  input  logic               pt_full_i,
  output logic               ct_pop_o,
  input  logic [WORD_W-1:0]  ct_i,
  input  logic               ct_empty_i
);

  localparam int unsigned CNT_W = DATA_AW + 1;

  job_state_e          state;
  logic [MEM_AW-1:0]   ad_base, pt_base, ct_base;
  logic [CNT_W-1:0]    rd_idx;
  logic [DATA_AW-1:0]  ct_cnt;
  logic                rd_inflight, rd_land, rd_is_pt;
  logic                skid_valid, skid_is_pt;
  logic [WORD_W-1:0]   skid_data, wr_data;
  logic                wr_pend, tag_seen;
  mem_req_t            wr_cmd, rd_cmd, arb_cmd;

  logic                feeding_c, rd_req_c, rd_take_c, rd_next_is_pt_c;
  logic                wr_gnt_c, rd_gnt_c;
  logic [CNT_W-1:0]    rd_total_c, pt_idx_c;

  // Read sequencing walks AD then PT with one combined index.
  always_comb begin
    feeding_c       = (state == START) || (state == RUN);
    rd_total_c      = CNT_W'(asc_ad_size_o) + CNT_W'(asc_pt_size_o);
    rd_next_is_pt_c = rd_idx >= CNT_W'(asc_ad_size_o);
    pt_idx_c        = rd_idx - CNT_W'(asc_ad_size_o);
    rd_req_c        = feeding_c && (rd_idx < rd_total_c) && !skid_valid &&
                      !rd_inflight && !wr_pend;
    rd_cmd.we       = 1'b0;
    rd_cmd.addr     = rd_next_is_pt_c ? pt_base + MEM_AW'(pt_idx_c)
                                      : ad_base + MEM_AW'(rd_idx);
    rd_cmd.wdata    = '0;
    wr_cmd.we       = 1'b1;
    wr_cmd.addr     = ct_base + MEM_AW'(ct_cnt);
    wr_cmd.wdata    = wr_data;
    wr_gnt_c        = mem_req_o && mem_we_o && mem_gnt_i;
    rd_gnt_c        = mem_req_o && !mem_we_o && mem_gnt_i;
    ad_push_o       = skid_valid && !skid_is_pt && !ad_full_i;
    pt_push_o       = skid_valid && skid_is_pt && !pt_full_i;
    ct_pop_o        = (state == RUN) && !ct_empty_i && !wr_pend &&
                      (ct_cnt < asc_pt_size_o);
  end

  assign ad_o        = skid_data;
  assign pt_o        = skid_data;
  assign mem_we_o    = arb_cmd.we;
  assign mem_addr_o  = arb_cmd.addr;
  assign mem_wdata_o = arb_cmd.wdata;

  ascon_mem_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .wr_req    (wr_pend),
    .wr        (wr_cmd),
    .rd_req    (rd_req_c),
    .rd        (rd_cmd),
    .rd_take_c (rd_take_c),
    .gnt       (mem_gnt_i),
    .req       (mem_req_o),
    .cmd       (arb_cmd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      tag_o         <= '0;
      asc_start_o   <= 1'b0;
      asc_ad_size_o <= '0;
      asc_pt_size_o <= '0;
      ad_base       <= '0;
      pt_base       <= '0;
      ct_base       <= '0;
      rd_idx        <= '0;
      ct_cnt        <= '0;
      rd_inflight   <= 1'b0;
      rd_land       <= 1'b0;
      rd_is_pt      <= 1'b0;
      skid_valid    <= 1'b0;
      skid_is_pt    <= 1'b0;
      skid_data     <= '0;
      wr_pend       <= 1'b0;
      wr_data       <= '0;
      tag_seen      <= 1'b0;
    end else begin
      asc_start_o <= 1'b0;
      done_o      <= 1'b0;
      case (state)
        IDLE: if (job_start_i) begin
          ad_base       <= ad_base_i;
          pt_base       <= pt_base_i;
          ct_base       <= ct_base_i;
          asc_ad_size_o <= ad_size_i;
          asc_pt_size_o <= pt_size_i;
          rd_idx        <= '0;
          ct_cnt        <= '0;
          tag_seen      <= 1'b0;
          busy_o        <= 1'b1;
          state         <= START;
        end
        START: if (asc_ready_i) begin
          asc_start_o <= 1'b1;
          state       <= RUN;
        end
        RUN: if ((ct_cnt == asc_pt_size_o) && tag_seen && !wr_pend) begin
          done_o <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (feeding_c && asc_tag_valid_i) begin
        tag_o    <= asc_tag_i;
        tag_seen <= 1'b1;
      end

      // Read data returns one cycle after its grant and lands in the skid.
      if (rd_take_c) begin
        rd_inflight <= 1'b1;
        rd_is_pt    <= rd_next_is_pt_c;
        rd_idx      <= rd_idx + CNT_W'(1);
      end
      rd_land <= rd_gnt_c;
      if (rd_land) begin
        skid_valid  <= 1'b1;
        skid_is_pt  <= rd_is_pt;
        skid_data   <= mem_rdata_i;
        rd_inflight <= 1'b0;
      end else if (ad_push_o || pt_push_o) begin
        skid_valid <= 1'b0;
      end

      if (ct_pop_o) begin
        wr_pend <= 1'b1;
        wr_data <= ct_i;
      end else if (wr_gnt_c) begin
        wr_pend <= 1'b0;
        ct_cnt  <= ct_cnt + DATA_AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ascon_job_sequencer.sv
// Directed bench for ascon_job_sequencer with a behavioural scratch memory and
// a stand-in wrapper whose CT word is its PT word XOR a fixed key.
module tb_ascon_job_sequencer;

  localparam logic [63:0]  INIT  = 64'h0123_4567_0000_0000;
  localparam logic [63:0]  KEY   = 64'hFFFF_0000_FFFF_0000;
  localparam logic [127:0] TAG_A = 128'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB_ACAD_AEAF;
  localparam logic [127:0] TAG_B = 128'hB000_0000_0000_0000_0000_0000_0000_000B;
  localparam logic [127:0] TAG_C = 128'hC0C0_C0C0_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] TAG_D = 128'hD00D_F00D_0000_0000_1234_5678_9ABC_DEF0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         job_start_i = 1'b0;
  logic [7:0]   ad_base_i = '0, pt_base_i = '0, ct_base_i = '0;
  logic [6:0]   ad_size_i = '0, pt_size_i = '0;
  logic         busy_o, done_o;
  logic [127:0] tag_o;
  logic         mem_req_o, mem_we_o, mem_gnt_i;
  logic [7:0]   mem_addr_o;
  logic [63:0]  mem_wdata_o;
  logic [63:0]  mem_rdata_i = '0;
  logic         asc_start_o;
  logic         asc_ready_i = 1'b1;
  logic [6:0]   asc_ad_size_o, asc_pt_size_o;
  logic         asc_tag_valid_i = 1'b0;
  logic [127:0] asc_tag_i = '0;
  logic         ad_push_o, pt_push_o, ct_pop_o;
  logic [63:0]  ad_o, pt_o;
  logic         ad_full_i, pt_full_i;
  logic [63:0]  ct_i = '0;
  logic         ct_empty_i = 1'b1;

  logic         hold_full = 1'b0;
  logic         stall_mode = 1'b0;
  logic         gnt_en = 1'b1;
  logic [63:0]  mem [256];
  logic [63:0]  ad_log[$], pt_log[$], ct_q[$];
  int           wr_cnt = 0;

  int unsigned  n_chk = 0, n_pass = 0;
  int           done_cnt = 0, start_cnt = 0, req_cnt = 0;
  logic         stab_en = 1'b1;
  logic         prev_req = 1'b0, prev_gnt = 1'b0, prev_we = 1'b0;
  logic [7:0]   prev_addr = '0;
  logic [63:0]  prev_wdata = '0;
  int           s0, d0, r0, a0, p0, w0;

  always #5 clk = ~clk;

  assign ad_full_i = hold_full;
  assign pt_full_i = hold_full;
  assign mem_gnt_i = mem_req_o & gnt_en;

  ascon_job_sequencer dut (
    .clk(clk), .rst(rst), .job_start_i(job_start_i),
    .ad_base_i(ad_base_i), .pt_base_i(pt_base_i), .ct_base_i(ct_base_i),
    .ad_size_i(ad_size_i), .pt_size_i(pt_size_i),
    .busy_o(busy_o), .done_o(done_o), .tag_o(tag_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rdata_i(mem_rdata_i),
    .asc_start_o(asc_start_o), .asc_ready_i(asc_ready_i),
    .asc_ad_size_o(asc_ad_size_o), .asc_pt_size_o(asc_pt_size_o),
    .asc_tag_valid_i(asc_tag_valid_i), .asc_tag_i(asc_tag_i),
    .ad_push_o(ad_push_o), .ad_o(ad_o), .ad_full_i(ad_full_i),
    .pt_push_o(pt_push_o), .pt_o(pt_o), .pt_full_i(pt_full_i),
    .ct_pop_o(ct_pop_o), .ct_i(ct_i), .ct_empty_i(ct_empty_i)
  );

  // Grant generator: always grant, or grant roughly one cycle in three.
  always @(posedge clk) begin
    #1;
    gnt_en = !stall_mode || ($urandom_range(0, 2) == 0);
  end

  // Scratch memory plus stand-in wrapper FIFOs.
  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 256; a++) mem[a] <= INIT | 64'(a);
      ad_log.delete();
      pt_log.delete();
      ct_q.delete();
      ct_empty_i  <= 1'b1;
      ct_i        <= '0;
      mem_rdata_i <= '0;
      wr_cnt      <= 0;
    end else begin
      if (mem_req_o && mem_gnt_i) begin
        if (mem_we_o) begin
          mem[mem_addr_o] <= mem_wdata_o;
          wr_cnt          <= wr_cnt + 1;
        end else begin
          mem_rdata_i <= mem[mem_addr_o];
        end
      end
      if (ad_push_o) ad_log.push_back(ad_o);
      if (ct_pop_o && ct_q.size() > 0) void'(ct_q.pop_front());
      if (pt_push_o) begin
        pt_log.push_back(pt_o);
        ct_q.push_back(pt_o ^ KEY);
      end
      ct_empty_i <= (ct_q.size() == 0);
      ct_i       <= (ct_q.size() > 0) ? ct_q[0] : 64'h0;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle step; also tallies pulses and checks request hold while stalled.
  task automatic tick();
    @(negedge clk);
    if (done_o) done_cnt++;
    if (asc_start_o) start_cnt++;
    if (mem_req_o) req_cnt++;
    if (stab_en && prev_req && !prev_gnt)
      check("req_hold", 128'({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}),
            128'({1'b1, prev_we, prev_addr, prev_wdata}));
    prev_req   = mem_req_o;
    prev_gnt   = mem_gnt_i;
    prev_we    = mem_we_o;
    prev_addr  = mem_addr_o;
    prev_wdata = mem_wdata_o;
  endtask

  task automatic start_job(input logic [7:0] ab, input logic [7:0] pb, input logic [7:0] cb,
                           input logic [6:0] asz, input logic [6:0] psz);
    ad_base_i = ab; pt_base_i = pb; ct_base_i = cb;
    ad_size_i = asz; pt_size_i = psz;
    job_start_i = 1'b1;
    tick();
    job_start_i = 1'b0;
  endtask

  task automatic pulse_tag(input logic [127:0] t);
    asc_tag_valid_i = 1'b1;
    asc_tag_i       = t;
    tick();
    asc_tag_valid_i = 1'b0;
  endtask

  task automatic wait_start(input int budget);
    int s = start_cnt;
    int n = 0;
    while (start_cnt == s && n < budget) begin
      tick();
      n++;
    end
    check("start_seen", 128'(start_cnt != s), 128'd1);
  endtask

  task automatic wait_done(input int budget, input int dref);
    int n = 0;
    while (done_cnt == dref && n < budget) begin
      tick();
      n++;
    end
    tick();
    tick();
    check("done_one_pulse", 128'(done_cnt - dref), 128'd1);
    check("idle_after_done", 128'(busy_o), 128'd0);
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    check("rst_outputs", 128'({busy_o, done_o, mem_req_o, asc_start_o, ad_push_o, pt_push_o, ct_pop_o}), 128'd0);
    check("rst_tag", tag_o, 128'd0);
    check("rst_sizes", 128'({asc_ad_size_o, asc_pt_size_o}), 128'd0);

    // Job A: FIFOs full and wrapper not ready for 20 cycles, then normal run.
    hold_full = 1'b1;
    asc_ready_i = 1'b0;
    s0 = start_cnt; d0 = done_cnt; r0 = req_cnt; a0 = ad_log.size(); p0 = pt_log.size();
    start_job(8'h10, 8'h20, 8'h40, 7'd2, 7'd3);
    repeat (20) tick();
    check("hold_one_read", 128'(req_cnt - r0), 128'd1);
    check("hold_no_push", 128'(ad_log.size() - a0 + pt_log.size() - p0), 128'd0);
    check("start_waits_ready", 128'(start_cnt - s0), 128'd0);
    check("busy_in_job", 128'(busy_o), 128'd1);
    hold_full = 1'b0;
    asc_ready_i = 1'b1;
    wait_start(20);
    repeat (3) tick();
    pulse_tag(TAG_A);
    wait_done(400, d0);
    check("a_start_width", 128'(start_cnt - s0), 128'd1);
    check("a_ad0", 128'(ad_log[a0]), 128'h0123_4567_0000_0010);
    check("a_ad1", 128'(ad_log[a0+1]), 128'h0123_4567_0000_0011);
    check("a_pt0", 128'(pt_log[p0]), 128'h0123_4567_0000_0020);
    check("a_pt2", 128'(pt_log[p0+2]), 128'h0123_4567_0000_0022);
    check("a_ct0", 128'(mem[8'h40]), 128'hFEDC_4567_FFFF_0020);
    check("a_ct1", 128'(mem[8'h41]), 128'hFEDC_4567_FFFF_0021);
    check("a_ct2", 128'(mem[8'h42]), 128'hFEDC_4567_FFFF_0022);
    check("a_tag", tag_o, TAG_A);

    // Job B: empty job finishes on the tag alone.
    s0 = start_cnt; d0 = done_cnt; r0 = req_cnt;
    start_job(8'h00, 8'h00, 8'h00, 7'd0, 7'd0);
    wait_start(10);
    repeat (6) tick();
    check("b_wait_tag", 128'(done_cnt - d0), 128'd0);
    pulse_tag(TAG_B);
    wait_done(10, d0);
    check("b_no_mem", 128'(req_cnt - r0), 128'd0);
    check("b_start_width", 128'(start_cnt - s0), 128'd1);
    check("b_tag", tag_o, TAG_B);

    // Job C: CT address wrap under random grant stalls, stray start ignored.
    stall_mode = 1'b1;
    s0 = start_cnt; d0 = done_cnt; w0 = wr_cnt; a0 = ad_log.size();
    start_job(8'h60, 8'h30, 8'hFE, 7'd1, 7'd4);
    repeat (3) tick();
    start_job(8'h70, 8'h70, 8'h80, 7'd5, 7'd5);
    check("c_sizes_kept", 128'({asc_ad_size_o, asc_pt_size_o}), 128'({7'd1, 7'd4}));
    pulse_tag(TAG_C);
    wait_done(3000, d0);
    stall_mode = 1'b0;
    check("c_start_width", 128'(start_cnt - s0), 128'd1);
    check("c_ad0", 128'(ad_log[a0]), 128'h0123_4567_0000_0060);
    check("c_ct_fe", 128'(mem[8'hFE]), 128'hFEDC_4567_FFFF_0030);
    check("c_ct_ff", 128'(mem[8'hFF]), 128'hFEDC_4567_FFFF_0031);
    check("c_ct_00", 128'(mem[8'h00]), 128'hFEDC_4567_FFFF_0032);
    check("c_ct_01", 128'(mem[8'h01]), 128'hFEDC_4567_FFFF_0033);
    check("c_wr_count", 128'(wr_cnt - w0), 128'd4);
    check("c_stray_base", 128'(mem[8'h80]), 128'h0123_4567_0000_0080);
    check("c_tag", tag_o, TAG_C);

    // Reset in RUN aborts the job.
    hold_full = 1'b1;
    d0 = done_cnt;
    start_job(8'h10, 8'h20, 8'h50, 7'd2, 7'd3);
    repeat (6) tick();
    stab_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hold_full = 1'b0;
    check("abort_outputs", 128'({busy_o, done_o, mem_req_o, asc_start_o, ad_push_o, pt_push_o, ct_pop_o}), 128'd0);
    check("abort_tag", tag_o, 128'd0);
    check("abort_sizes", 128'({asc_ad_size_o, asc_pt_size_o}), 128'd0);
    tick();
    stab_en = 1'b1;
    check("abort_no_done", 128'(done_cnt - d0), 128'd0);

    // Job D: fresh job after the abort.
    d0 = done_cnt; a0 = ad_log.size(); p0 = pt_log.size();
    start_job(8'h10, 8'h20, 8'h50, 7'd2, 7'd3);
    wait_start(20);
    repeat (2) tick();
    pulse_tag(TAG_D);
    wait_done(400, d0);
    check("d_ad1", 128'(ad_log[a0+1]), 128'h0123_4567_0000_0011);
    check("d_pt1", 128'(pt_log[p0+1]), 128'h0123_4567_0000_0021);
    check("d_ct0", 128'(mem[8'h50]), 128'hFEDC_4567_FFFF_0020);
    check("d_ct2", 128'(mem[8'h52]), 128'hFEDC_4567_FFFF_0022);
    check("d_tag", tag_o, TAG_D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
